// File: rtl/uart_program_loader_pkg.sv
// Shared types and constants for the UART program loader.
package uart_program_loader_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned CNT_W  = 6;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_ARMED,
    LD_WRITE,
    LD_DONE,
    LD_ERROR
  } ld_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_program_loader_if.sv
// Program-memory write port plus loader status, as seen by the CPU side.
interface uart_program_loader_if;
  import uart_program_loader_pkg::*;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              busy;
  logic              done;
  logic              fe;
  logic [CNT_W-1:0]  byte_count;

  modport master (
    output mem_we, mem_addr, mem_data, busy, done, fe, byte_count
  );

  modport slave (
    input mem_we, mem_addr, mem_data, busy, done, fe, byte_count
  );
endinterface

// File: rtl/uart_program_loader_rx_core.sv
// 8N1 UART receiver: 2-FF synchroniser, half-bit start qualification,
// mid-bit sampling, one-cycle byte_valid / frame_err pulses.
module uart_rx_core
  import uart_program_loader_pkg::*;
#(
  parameter int unsigned BAUDRATE = 868
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_data_o,
  output logic       frame_err_o
);

  localparam int unsigned CW = $clog2(BAUDRATE);
  localparam logic [CW-1:0] HALF_M1 = CW'(BAUDRATE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(BAUDRATE - 1);

  logic            rx_meta_q, rx_s_q, rx_prev_q;
  rx_state_e       state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic            valid_q, ferr_q;
  logic [7:0]      data_q;

  // A held-low line yields no new falling edge, so a break reports once only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      data_q    <= '0;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          if (rx_prev_q && !rx_s_q) begin
            cnt_q   <= HALF_M1;
            state_q <= RX_START;
          end
        end
        RX_START: begin
          if (cnt_q == '0) begin
            if (!rx_s_q) begin
              cnt_q   <= FULL_M1;
              bit_q   <= '0;
              state_q <= RX_DATA;
            end else begin
              state_q <= RX_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt_q == '0) begin
            shift_q <= {rx_s_q, shift_q[7:1]};
            cnt_q   <= FULL_M1;
            if (bit_q == 3'd7) begin
              state_q <= RX_STOP;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt_q == '0) begin
            if (rx_s_q) begin
              valid_q <= 1'b1;
              data_q  <= shift_q;
            end else begin
              ferr_q  <= 1'b1;
            end
            state_q <= RX_IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign byte_valid_o = valid_q;
  assign byte_data_o  = data_q;
  assign frame_err_o  = ferr_q;

endmodule

// File: rtl/uart_program_loader.sv
// Loads PROG_LEN bytes received over UART into consecutive program-memory
// addresses; reports completion or framing error to the control unit.
module uart_program_loader
  import uart_program_loader_pkg::*;
#(
  parameter int unsigned BAUDRATE = 868,
  parameter int unsigned PROG_LEN = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   rx_i,
  input  logic                   load_i,
  uart_program_loader_if.master  mem
);

  logic       byte_valid, frame_err;
  logic [7:0] byte_data;

  uart_rx_core #(
    .BAUDRATE (BAUDRATE)
  ) u_rx (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .rx_i         (rx_i),
    .byte_valid_o (byte_valid),
    .byte_data_o  (byte_data),
    .frame_err_o  (frame_err)
  );

  ld_state_e         state_q;
  logic              load_q;
  logic              we_q, busy_q, done_q, fe_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        data_q;
  logic [CNT_W-1:0]  count_q;
  logic              load_rise;

  assign load_rise = load_i && !load_q;

  // Restart has priority over everything, including a coincident byte_valid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= LD_IDLE;
      load_q  <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fe_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      load_q <= load_i;
      we_q   <= 1'b0;
      if (load_rise) begin
        state_q <= LD_ARMED;
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
        fe_q    <= 1'b0;
        addr_q  <= '0;
        count_q <= '0;
      end else begin
        case (state_q)
          LD_ARMED: begin
            if (byte_valid) begin
              we_q    <= 1'b1;
              data_q  <= byte_data;
              count_q <= count_q + 1'b1;
              state_q <= LD_WRITE;
            end else if (frame_err) begin
              fe_q    <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= LD_ERROR;
            end
          end
          LD_WRITE: begin
            if (count_q == CNT_W'(PROG_LEN)) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= LD_DONE;
            end else begin
              addr_q  <= addr_q + 1'b1;
              state_q <= LD_ARMED;
            end
          end
          LD_IDLE, LD_DONE, LD_ERROR: ;
          default: state_q <= LD_IDLE;
        endcase
      end
    end
  end

  assign mem.mem_we     = we_q;
  assign mem.mem_addr   = addr_q;
  assign mem.mem_data   = data_q;
  assign mem.busy       = busy_q;
  assign mem.done       = done_q;
  assign mem.fe         = fe_q;
  assign mem.byte_count = count_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Scoreboard bench: stimulus pushes expected writes, a monitor pops on Mem_we.
module tb_uart_program_loader;
  import uart_program_loader_pkg::*;

  localparam int unsigned BAUD = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic load = 1'b0;

  int checks = 0;
  int fails = 0;
  int writes_seen = 0;
  logic [12:0] exp_q[$];

  uart_program_loader_if bus ();

  uart_program_loader #(
    .BAUDRATE (BAUD),
    .PROG_LEN (32)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .rx_i   (rx),
    .load_i (load),
    .mem    (bus)
  );

  always #2 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.mem_we) begin
      logic [12:0] e;
      writes_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                 bus.mem_addr, bus.mem_data);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", int'(bus.mem_addr), int'(e[12:8]));
        check("write_data", int'(bus.mem_data), int'(e[7:0]));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no end of stimulus expected finish");
    $fatal(1);
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_load();
    @(negedge clk) load = 1'b1;
    @(negedge clk) load = 1'b0;
    cycles(3);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    cycles(BAUD);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cycles(BAUD);
    end
    rx = stop;
    cycles(BAUD);
    rx = 1'b1;
    cycles(4);
  endtask

  task automatic expect_write(input int a, input int d);
    exp_q.push_back({5'(a), 8'(d)});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"},    int'(bus.mem_we), 0);
    check({tag, "_addr"},  int'(bus.mem_addr), 0);
    check({tag, "_data"},  int'(bus.mem_data), 0);
    check({tag, "_busy"},  int'(bus.busy), 0);
    check({tag, "_done"},  int'(bus.done), 0);
    check({tag, "_fe"},    int'(bus.fe), 0);
    check({tag, "_count"}, int'(bus.byte_count), 0);
  endtask

  initial begin
    int w0;
    // Reset with RX toggling
    for (int i = 0; i < 10; i++) begin
      @(negedge clk) rx = ~rx;
    end
    rx = 1'b1;
    check_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    cycles(1000);
    check("idle_no_write", writes_seen, 0);

    // Single byte
    pulse_load();
    check("armed_busy", int'(bus.busy), 1);
    expect_write(0, 8'hA5);
    send_byte(8'hA5, 1'b1);
    check("single_count", int'(bus.byte_count), 1);
    check("single_busy", int'(bus.busy), 1);
    check("single_done", int'(bus.done), 0);

    // Full load of 32 bytes, then an extra byte that must be ignored
    pulse_load();
    check("reload_count", int'(bus.byte_count), 0);
    for (int i = 0; i < 32; i++) begin
      expect_write(i, i);
      send_byte(8'(i), 1'b1);
    end
    check("full_done", int'(bus.done), 1);
    check("full_busy", int'(bus.busy), 0);
    check("full_count", int'(bus.byte_count), 32);
    check("full_last_addr", int'(bus.mem_addr), 31);
    w0 = writes_seen;
    send_byte(8'hFF, 1'b1);
    check("extra_no_write", writes_seen, w0);
    check("extra_count", int'(bus.byte_count), 32);

    // Framing error on the third byte
    pulse_load();
    check("fe_reload_done", int'(bus.done), 0);
    expect_write(0, 8'h11);
    expect_write(1, 8'h22);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    w0 = writes_seen;
    send_byte(8'h33, 1'b0);
    cycles(10);
    check("fe_no_write", writes_seen, w0);
    check("fe_flag", int'(bus.fe), 1);
    check("fe_busy", int'(bus.busy), 0);
    check("fe_count", int'(bus.byte_count), 2);
    pulse_load();
    check("fe_cleared", int'(bus.fe), 0);
    expect_write(0, 8'h44);
    send_byte(8'h44, 1'b1);

    // Glitch rejection while armed
    pulse_load();
    rx = 1'b0;
    cycles(8);
    rx = 1'b1;
    cycles(40);
    check("glitch_fe", int'(bus.fe), 0);
    check("glitch_count", int'(bus.byte_count), 0);
    check("glitch_busy", int'(bus.busy), 1);
    expect_write(0, 8'h5A);
    send_byte(8'h5A, 1'b1);

    // Reset during bit 4 of the third byte
    pulse_load();
    expect_write(0, 8'h01);
    expect_write(1, 8'h02);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    rx = 1'b0;
    cycles(BAUD);
    for (int i = 0; i < 4; i++) begin
      rx = (i < 2) ? 1'b1 : 1'b0;
      cycles(BAUD);
    end
    rx = 1'b0;
    cycles(10);
    rst_n = 1'b0;
    rx = 1'b1;
    cycles(2);
    check_all_zero("midrst");
    cycles(5);
    rst_n = 1'b1;
    cycles(30);
    check("midrst_post_count", int'(bus.byte_count), 0);
    pulse_load();
    expect_write(0, 8'h77);
    send_byte(8'h77, 1'b1);
    check("midrst_count", int'(bus.byte_count), 1);

    cycles(20);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
